// File: rtl/ula_pkg.sv
// Opcode and width constants shared by the ula and the requesters that drive it.
package ula_pkg;

  localparam int DATA_W   = 32;
  localparam int ULA_OP_W = 4;

  localparam logic [ULA_OP_W-1:0] ULA_ADD  = 4'b0000;
  localparam logic [ULA_OP_W-1:0] ULA_SUB  = 4'b0001;
  localparam logic [ULA_OP_W-1:0] ULA_SLT  = 4'b0010;
  localparam logic [ULA_OP_W-1:0] ULA_AND  = 4'b0011;
  localparam logic [ULA_OP_W-1:0] ULA_NOR  = 4'b0100;
  localparam logic [ULA_OP_W-1:0] ULA_OR   = 4'b0101;
  localparam logic [ULA_OP_W-1:0] ULA_XOR  = 4'b0110;
  localparam logic [ULA_OP_W-1:0] ULA_SLL  = 4'b0111;
  localparam logic [ULA_OP_W-1:0] ULA_SRA  = 4'b1000;
  localparam logic [ULA_OP_W-1:0] ULA_SRL  = 4'b1001;
  localparam logic [ULA_OP_W-1:0] ULA_SLTU = 4'b1010;

  typedef logic [DATA_W-1:0]   ula_word_t;
  typedef logic [ULA_OP_W-1:0] ula_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first set request at or after ptr_i, wrapping to index 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    // Upper pass covers ptr..N-1; lower pass supplies the wrapped 0..ptr-1 part.
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_i))) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = PW'(i);
      end
    end
  end

endmodule

// File: rtl/ula.sv
// Combinational 32-bit ALU; shift amount is the full In2 value, undefined opcodes give 0.
module ula
  import ula_pkg::*;
(
  input  logic [ULA_OP_W-1:0] op_i,
  input  logic [DATA_W-1:0]   in1_i,
  input  logic [DATA_W-1:0]   in2_i,
  output logic [DATA_W-1:0]   result_o,
  output logic                zero_o
);

  logic signed [DATA_W-1:0] in1_s;
  logic signed [DATA_W-1:0] in2_s;
  logic signed [DATA_W-1:0] sra_s;

  assign in1_s = in1_i;
  assign in2_s = in2_i;
  assign sra_s = in1_s >>> in2_i;

  always_comb begin
    result_o = '0;
    case (op_i)
      ULA_ADD:  result_o = in1_i + in2_i;
      ULA_SUB:  result_o = in1_i - in2_i;
      ULA_SLT:  result_o = {{(DATA_W-1){1'b0}}, (in1_s < in2_s)};
      ULA_AND:  result_o = in1_i & in2_i;
      ULA_NOR:  result_o = ~(in1_i | in2_i);
      ULA_OR:   result_o = in1_i | in2_i;
      ULA_XOR:  result_o = in1_i ^ in2_i;
      ULA_SLL:  result_o = in1_i << in2_i;
      ULA_SRA:  result_o = sra_s;
      ULA_SRL:  result_o = in1_i >> in2_i;
      ULA_SLTU: result_o = {{(DATA_W-1){1'b0}}, (in1_i < in2_i)};
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/ula_arbiter.sv
// Shares one ula among N_REQ requesters: round-robin grant, one-deep registered response.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [4*N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0]   req_in1,
  input  logic [32*N_REQ-1:0]   req_in2,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DATA_W-1:0]     rsp_result,
  output logic                  rsp_zero
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;

  logic [N_REQ-1:0]    grant;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W-1:0]    ptr_next;
  logic                can_accept;
  logic                accept;
  logic [ULA_OP_W-1:0] op_sel;
  logic [DATA_W-1:0]   in1_sel;
  logic [DATA_W-1:0]   in2_sel;
  logic [DATA_W-1:0]   ula_result;
  logic                ula_zero;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PTR_W)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  // A retiring response frees the register in the same cycle, so accept back-to-back.
  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
  assign accept     = can_accept && (|grant) && !rst;
  assign req_ready  = accept ? grant : '0;

  always_comb begin
    op_sel  = '0;
    in1_sel = '0;
    in2_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        op_sel  = op_sel  | req_op[4*i +: 4];
        in1_sel = in1_sel | req_in1[32*i +: 32];
        in2_sel = in2_sel | req_in2[32*i +: 32];
      end
    end
  end

  ula u_ula (
    .op_i     (op_sel),
    .in1_i    (in1_sel),
    .in2_i    (in2_sel),
    .result_o (ula_result),
    .zero_o   (ula_zero)
  );

  assign ptr_next = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + PTR_W'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rsp_id_d = rsp_id_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (accept) begin
      state_d  = ST_FULL;
      ptr_d    = ptr_next;
      rsp_id_d = ID_W'(grant_idx);
      result_d = ula_result;
      zero_d   = ula_zero;
    end else if (rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= '0;
      rsp_id_q <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rsp_id_q <= rsp_id_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign rsp_valid  = (state_q == ST_FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed plus randomized bench for ula_arbiter against a queue-free behavioural model.
module tb_ula_arbiter;
  import ula_pkg::*;

  localparam int N    = 2;
  localparam int ID_W = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [4*N-1:0]  req_op;
  logic [32*N-1:0] req_in1;
  logic [32*N-1:0] req_in2;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_zero;

  ula_arbiter #(.N_REQ(N), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          m_valid;
  int          m_id;
  logic [31:0] m_res;
  bit          m_zero;
  int          m_ptr;
  int          last_g;

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return a & b;
      4'd4:  return ~(a | b);
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return (b >= 32) ? 32'd0 : 32'(a * (64'd1 << b));
      4'd8:  return (b >= 32) ? {32{a[31]}} : 32'(sa / (64'sd1 << b) - ((sa < 0 && (sa % (64'sd1 << b)) != 0) ? 1 : 0));
      4'd9:  return (b >= 32) ? 32'd0 : 32'(a / (64'd1 << b));
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_grant();
    if (rst) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int i, bit v, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    req_valid[i]       = v;
    req_op[4*i +: 4]   = op;
    req_in1[32*i +: 32] = a;
    req_in2[32*i +: 32] = b;
  endtask

  // One clock: check grant before the edge, advance the model, check the response after it.
  task automatic cycle();
    int g;
    logic [31:0] exp_rdy;
    #2;
    g = ref_grant();
    exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
    chk("req_ready", 32'(req_ready), exp_rdy);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1;
      m_id    = g;
      m_res   = ref_alu(req_op[4*g +: 4], req_in1[32*g +: 32], req_in2[32*g +: 32]);
      m_zero  = (m_res == 0);
      m_ptr   = (g + 1) % N;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    last_g = g;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
  endtask

  logic [31:0] held_res;
  int          g_prev;

  initial begin
    m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_ptr = 0; last_g = -1;
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0; req_op = '0; req_in1 = '0; req_in2 = '0;
    set_req(0, 1, ULA_ADD, 32'd1, 32'd1);
    set_req(1, 1, ULA_ADD, 32'd2, 32'd2);
    @(posedge clk); #1;

    // Reset held with both requesting
    cycle();
    cycle();
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_result", rsp_result, 32'd0);

    // Single ADD
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1, ULA_ADD, 32'd5, 32'd7);
    set_req(1, 0, ULA_ADD, 32'd0, 32'd0);
    cycle();
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_result", rsp_result, 32'd12);
    chk("single_zero", 32'(rsp_zero), 32'd0);
    set_req(0, 0, ULA_ADD, 32'd0, 32'd0);
    cycle();

    // Fairness: both valid every cycle
    set_req(0, 1, ULA_ADD, 32'd1, 32'd2);
    set_req(1, 1, ULA_SUB, 32'd9, 32'd9);
    g_prev = -1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (g_prev >= 0) chk("fair_alternate", 32'(last_g), 32'((g_prev + 1) % N));
      g_prev = last_g;
      if (last_g == 1) begin
        chk("sub_result", rsp_result, 32'd0);
        chk("sub_zero", 32'(rsp_zero), 32'd1);
      end
    end

    // Backpressure while FULL
    rsp_ready = 1'b0;
    held_res = rsp_result;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_hold", rsp_result, held_res);
    end
    rsp_ready = 1'b1;
    #2;
    chk("bp_release", 32'(|req_ready), 32'd1);
    cycle();

    // Opcode corner cases, one requester only
    set_req(1, 0, ULA_ADD, 32'd0, 32'd0);
    set_req(0, 1, ULA_SLT, 32'hFFFF_FFFF, 32'd1);  cycle(); chk("slt", rsp_result, 32'd1);
    set_req(0, 1, ULA_SLTU, 32'hFFFF_FFFF, 32'd1); cycle(); chk("sltu", rsp_result, 32'd0);
    set_req(0, 1, ULA_SRA, 32'h8000_0000, 32'd4);  cycle(); chk("sra", rsp_result, 32'hF800_0000);
    set_req(0, 1, 4'b1111, 32'h1234, 32'h5678);    cycle(); chk("undef_res", rsp_result, 32'd0);
    chk("undef_zero", 32'(rsp_zero), 32'd1);
    set_req(0, 1, ULA_SLL, 32'h0000_0001, 32'd40); cycle(); chk("sll_big", rsp_result, 32'd0);
    set_req(0, 1, ULA_SRA, 32'h8000_0000, 32'd40); cycle(); chk("sra_big", rsp_result, 32'hFFFF_FFFF);

    // Reset while a response is stalled
    rsp_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    cycle();
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1, ULA_OR, 32'h00F0, 32'h0F00);
    set_req(1, 1, ULA_XOR, 32'h3, 32'h3);
    cycle();
    chk("first_grant_after_rst", 32'(rsp_id), 32'd0);
    chk("or_result", rsp_result, 32'h0FF0);

    // Randomized traffic with the hold-until-accepted rule
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_g == i) begin
          logic [31:0] a, b;
          a = $urandom();
          b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
          if ($urandom_range(0, 5) == 0) b = a;
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, b);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      if (rst) rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
